// File: rtl/dense_accumulator_pkg.sv
// Shared definitions for the dense accumulator: FSM state codes, default sizes and width helpers.
// Optional fused ReLU is selected by defining DENSE_RELU_EN (see dense_sat_lane).
package dense_accumulator_pkg;

  typedef enum logic [1:0] {
    DACC_IDLE  = 2'd0,
    DACC_ACCUM = 2'd1,
    DACC_DONE  = 2'd2
  } dacc_state_e;

  localparam int DENSE_BIT_DATA = 8;
  localparam int DENSE_KSIZE    = 4;
  localparam int DENSE_N_IN     = 64;

  // Accumulator wide enough that N_IN full-scale products can never overflow.
  function automatic int acc_width(input int bit_data, input int n_in);
    return 2 * bit_data + $clog2(n_in) + 1;
  endfunction

  function automatic int cnt_width(input int n_in);
    return (n_in > 1) ? $clog2(n_in) : 1;
  endfunction

endpackage

// File: rtl/dense_sat_lane.sv
// One output lane: arithmetic right shift, saturation to BIT_OUT signed range, and
// (with DENSE_RELU_EN defined) clamping of negative results to zero.
module dense_sat_lane
  import dense_accumulator_pkg::*;
#(
  parameter int BIT_IN  = 19,
  parameter int BIT_OUT = 8,
  parameter int SHIFT   = 0
) (
  input  logic signed [BIT_IN-1:0]  acc,
  output logic signed [BIT_OUT-1:0] sat
);

  localparam logic signed [BIT_IN-1:0] MAX_V =
    {{(BIT_IN-BIT_OUT+1){1'b0}}, {(BIT_OUT-1){1'b1}}};
  localparam logic signed [BIT_IN-1:0] MIN_V =
    {{(BIT_IN-BIT_OUT+1){1'b1}}, {(BIT_OUT-1){1'b0}}};

  logic signed [BIT_IN-1:0]  shifted_s;
  logic signed [BIT_OUT-1:0] clip_s;

  // >>> on a signed operand rounds toward minus infinity.
  assign shifted_s = acc >>> SHIFT;

  // Saturate the rescaled sum into the output range.
  always_comb begin
    clip_s = shifted_s[BIT_OUT-1:0];
    if (shifted_s > MAX_V) begin
      clip_s = MAX_V[BIT_OUT-1:0];
    end else if (shifted_s < MIN_V) begin
      clip_s = MIN_V[BIT_OUT-1:0];
    end else begin
      clip_s = shifted_s[BIT_OUT-1:0];
    end
  end

  // Optional fused ReLU on the saturated value.
  always_comb begin
    sat = clip_s;
`ifdef DENSE_RELU_EN
    if (clip_s[BIT_OUT-1]) begin
      sat = {BIT_OUT{1'b0}};
    end else begin
      sat = clip_s;
    end
`else
    sat = clip_s;
`endif
  end

endmodule

// File: rtl/dense_accumulator.sv
// Sums KSIZE signed product lanes over N_IN beats, then rescales/saturates each lane and
// presents the frame result on a valid/ready output. Fused ReLU when DENSE_RELU_EN is defined.
module dense_accumulator
  import dense_accumulator_pkg::*;
#(
  parameter int BIT_DATA = DENSE_BIT_DATA,
  parameter int KSIZE    = DENSE_KSIZE,
  parameter int N_IN     = DENSE_N_IN,
  parameter int SHIFT    = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        prod_valid,
  output logic                        prod_ready,
  input  logic [KSIZE*2*BIT_DATA-1:0] prod_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [KSIZE*BIT_DATA-1:0]   out_data,
  output logic                        busy
);

  localparam int BIT_PROD = 2 * BIT_DATA;
  localparam int BIT_ACC  = acc_width(BIT_DATA, N_IN);
  localparam int CNT_W    = cnt_width(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  dacc_state_e state_r, state_nxt_s;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [BIT_ACC-1:0] acc_r [KSIZE];
  logic signed [BIT_ACC-1:0] sum_s [KSIZE];
  logic [KSIZE*BIT_DATA-1:0] sat_s;
  logic [KSIZE*BIT_DATA-1:0] out_data_r;
  logic out_valid_r, prod_ready_r, busy_r;
  logic beat_s, last_s, handshake_s, restart_s;

  assign beat_s      = prod_valid & prod_ready_r;
  assign last_s      = beat_s & (cnt_r == CNT_LAST);
  assign handshake_s = out_valid_r & out_ready;

  assign prod_ready = prod_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign busy       = busy_r;

  // Per lane: running sum including the current beat, then rescale/saturate.
  for (genvar k = 0; k < KSIZE; k++) begin : g_lane
    logic signed [BIT_PROD-1:0] lane_s;
    assign lane_s   = prod_data[BIT_PROD*k +: BIT_PROD];
    assign sum_s[k] = acc_r[k] + {{(BIT_ACC-BIT_PROD){lane_s[BIT_PROD-1]}}, lane_s};

    dense_sat_lane #(
      .BIT_IN  (BIT_ACC),
      .BIT_OUT (BIT_DATA),
      .SHIFT   (SHIFT)
    ) u_sat (
      .acc (sum_s[k]),
      .sat (sat_s[BIT_DATA*k +: BIT_DATA])
    );
  end

  // Next-state decode; restart_s marks a frame start that clears acc/cnt.
  always_comb begin
    state_nxt_s = state_r;
    restart_s   = 1'b0;
    case (state_r)
      DACC_IDLE: begin
        if (start) begin
          state_nxt_s = DACC_ACCUM;
          restart_s   = 1'b1;
        end else begin
          state_nxt_s = DACC_IDLE;
        end
      end
      DACC_ACCUM: begin
        if (last_s) begin
          state_nxt_s = DACC_DONE;
        end else begin
          state_nxt_s = DACC_ACCUM;
        end
      end
      DACC_DONE: begin
        if (handshake_s && start) begin
          state_nxt_s = DACC_ACCUM;
          restart_s   = 1'b1;
        end else if (handshake_s) begin
          state_nxt_s = DACC_IDLE;
        end else begin
          state_nxt_s = DACC_DONE;
        end
      end
      default: begin
        state_nxt_s = DACC_IDLE;
      end
    endcase
  end

  // State, beat counter and registered status/output flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= DACC_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      prod_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {(KSIZE*BIT_DATA){1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      prod_ready_r <= (state_nxt_s == DACC_ACCUM);
      busy_r       <= (state_nxt_s != DACC_IDLE);
      if (restart_s || last_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (beat_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      // Result captured on the final beat so out_valid rises one cycle after it.
      if (last_s) begin
        out_data_r  <= sat_s;
        out_valid_r <= 1'b1;
      end else if (handshake_s) begin
        out_data_r  <= out_data_r;
        out_valid_r <= 1'b0;
      end else begin
        out_data_r  <= out_data_r;
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Lane accumulators: cleared on frame start, updated on every accepted beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < KSIZE; k++) begin
        acc_r[k] <= {BIT_ACC{1'b0}};
      end
    end else begin
      for (int k = 0; k < KSIZE; k++) begin
        if (restart_s) begin
          acc_r[k] <= {BIT_ACC{1'b0}};
        end else if (beat_s) begin
          acc_r[k] <= sum_s[k];
        end else begin
          acc_r[k] <= acc_r[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_accumulator.sv
// Bench for dense_accumulator: two instances (SHIFT=0 and SHIFT=2) driven with identical
// frames, compared against an integer reference model. Honours DENSE_RELU_EN when defined.
module tb_dense_accumulator;

  localparam int B = 8;
  localparam int K = 4;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset, start, prod_valid, out_ready;
  logic [K*2*B-1:0] prod_data;
  logic prod_ready0, out_valid0, busy0, prod_ready2, out_valid2, busy2;
  logic [K*B-1:0] out_data0, out_data2;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_m[K];
  int lv[K];

  always #5 clock = ~clock;

  dense_accumulator #(.BIT_DATA(B), .KSIZE(K), .N_IN(N), .SHIFT(0)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .prod_valid(prod_valid),
    .prod_ready(prod_ready0), .prod_data(prod_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .busy(busy0));

  dense_accumulator #(.BIT_DATA(B), .KSIZE(K), .N_IN(N), .SHIFT(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start), .prod_valid(prod_valid),
    .prod_ready(prod_ready2), .prod_data(prod_data), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .busy(busy2));

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    else return -((-s + d - 1) / d);
  endfunction

  function automatic int ref_lane(input int s, input int sh);
    int v;
    v = floor_div(s, 1 << sh);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef DENSE_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic logic [31:0] ref_out(input int sh);
    logic [31:0] r;
    int t;
    r = 32'd0;
    for (int k = 0; k < K; k++) begin
      t = ref_lane(acc_m[k], sh);
      r[8*k +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic clear_model();
    for (int k = 0; k < K; k++) acc_m[k] = 0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    clear_model();
    chk1("start_ready", prod_ready0, 1'b1);
    chk1("start_busy", busy0, 1'b1);
    chk1("start_valid_low", out_valid0, 1'b0);
  endtask

  // Idle gap (with stray start pulses that must be ignored), then one beat of lv[].
  task automatic beat_go(input int gap);
    for (int g = 0; g < gap; g++) begin
      prod_valid = 1'b0;
      prod_data  = {$urandom, $urandom};
      start      = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    start = 1'b0;
    chk1("ready_before_beat", prod_ready0, 1'b1);
    chk1("valid_low_in_accum", out_valid0, 1'b0);
    prod_valid = 1'b1;
    for (int k = 0; k < K; k++) begin
      prod_data[16*k +: 16] = lv[k][15:0];
      acc_m[k] += lv[k];
    end
    @(negedge clock);
    prod_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    chk1({tag, "_valid0"}, out_valid0, 1'b1);
    chk1({tag, "_valid2"}, out_valid2, 1'b1);
    chk1({tag, "_ready_low"}, prod_ready0, 1'b0);
    chk1({tag, "_busy2"}, busy2, 1'b1);
    chk({tag, "_data0"}, out_data0, ref_out(0));
    chk({tag, "_data2"}, out_data2, ref_out(2));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk1("hs_valid0_low", out_valid0, 1'b0);
    chk1("hs_valid2_low", out_valid2, 1'b0);
    chk1("hs_idle", busy0, 1'b0);
    chk1("hs_ready2_low", prod_ready2, 1'b0);
  endtask

  task automatic const_frame(input int v, input int gap);
    start_frame();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) lv[k] = v;
      beat_go(gap);
    end
  endtask

  initial begin
    logic [31:0] held;
    int a6[4];
    int b6[4];
    int c6[4];
    int d6[4];
    reset = 1'b1; start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
    prod_data = {(K*2*B){1'b0}};
    clear_model();
    repeat (2) @(negedge clock);
    chk1("rst_valid", out_valid0, 1'b0);
    chk("rst_data", out_data0, 32'd0);
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_ready", prod_ready2, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Uniform +10 lanes.
    const_frame(10, 0);
    finish_check("t1");
    chk("t1_value", out_data0, 32'h28282828);
    handshake();

    // Saturation in both directions; then hold the result with out_ready low.
    start_frame();
    for (int i = 0; i < N; i++) begin
      lv[0] = 100; lv[1] = -100; lv[2] = 1; lv[3] = -1;
      beat_go(0);
    end
    finish_check("t2");
    held = out_data0;
    prod_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      prod_data = {$urandom, $urandom};
      start = 1'b0;
      @(negedge clock);
      chk("t3_stable", out_data0, held);
      chk1("t3_ready_low", prod_ready0, 1'b0);
      chk1("t3_valid", out_valid0, 1'b1);
    end
    prod_valid = 1'b0;
    handshake();

    // Reset mid-frame leaves no residue.
    start_frame();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < K; k++) lv[k] = 50;
      beat_go(0);
    end
    reset = 1'b1;
    #2;
    chk1("t4_async_busy", busy0, 1'b0);
    chk1("t4_async_ready", prod_ready0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    const_frame(1, 0);
    finish_check("t4");

    // Back-to-back: handshake and start in the same DONE cycle.
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    start = 1'b0;
    clear_model();
    chk1("t5_ready", prod_ready0, 1'b1);
    chk1("t5_valid_low", out_valid0, 1'b0);
    chk1("t5_busy", busy0, 1'b1);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) lv[k] = 2;
      beat_go(0);
    end
    finish_check("t5");
    handshake();

    // Floor rescale on the SHIFT=2 instance, with 3-cycle gaps.
    a6 = '{-2, 2, -1, 1};
    b6 = '{-1, 2, 0, 1};
    c6 = '{-1, 2, 0, 1};
    d6 = '{-1, 1, 0, 0};
    start_frame();
    for (int k = 0; k < K; k++) lv[k] = a6[k];
    beat_go(3);
    for (int k = 0; k < K; k++) lv[k] = b6[k];
    beat_go(3);
    for (int k = 0; k < K; k++) lv[k] = c6[k];
    beat_go(3);
    for (int k = 0; k < K; k++) lv[k] = d6[k];
    beat_go(3);
    finish_check("t6");
    handshake();

    // Random frames with random gaps.
    for (int f = 0; f < 6; f++) begin
      start_frame();
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < K; k++) lv[k] = int'($signed(16'($urandom)));
        beat_go(int'($urandom_range(0, 2)));
      end
      finish_check("rnd");
      handshake();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
